fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the team's synchronous FIFO between NUM_REQ producers.
- Arbitration is round-robin, with bounded burst ownership.
- Issues registered writes and throttles on the FIFO full/almostfull flags so no write ever overflows.
- Cross-checks the FIFO's wr_ack/overflow responses and halts granting on any protocol error until software clears it.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter family.
// Contents: arbiter state enum, beat counter width, round-robin index step.
// No logic of its own; imported by the arbiter top and its picker.
package fifo_arb_pkg;

    // IDLE : no owner, waiting for a request with FIFO space
    // BURST: an owner holds the port for up to MAX_BURST beats
    // ERR  : protocol error seen, granting halted until err_clr
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ERR   = 2'd2
    } arb_state_t;

    // Wide enough for MAX_BURST up to 15.
    localparam int BEAT_W = 4;

    // Next index after idx, wrapping modulo n.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set bit of req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   req  - request vector
//   ptr  - index with highest priority this cycle
//   gnt  - one-hot winner (zero if no request)
//   idx  - winner index (zero if no request)
//   any  - at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk the requesters in priority order starting at ptr; the first
    // one found wins and later candidates are ignored.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one synchronous-FIFO write port among NUM_REQ producers, round-robin with bounded bursts.
// Latency: gnt is combinational; the granted beat appears on fifo_wr_en/fifo_data_in one cycle later.
// Backpressure: no grant while the FIFO is full or about to fill; stalls keep ownership and beat count.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req, req_data      - per-producer request and data (slice i belongs to req[i])
//   gnt                - one-hot grant, data slice is consumed at this edge
//   fifo_wr_en/data_in - registered FIFO write
//   fifo_full/almostfull/wr_ack/overflow - FIFO status and responses
//   err_clr            - clears sticky errors, leaves ERR
//   owner              - current/last granted producer
//   err_ack_missing, err_overflow - sticky protocol error flags
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    input  logic                      fifo_full,
    input  logic                      fifo_almostfull,
    input  logic                      fifo_wr_ack,
    input  logic                      fifo_overflow,
    input  logic                      err_clr,
    output logic [IW-1:0]             owner,
    output logic                      err_ack_missing,
    output logic                      err_overflow
);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              wen_prev_q;

    logic              space_ok;
    logic              ack_fail;
    logic              err_now;
    logic [IW-1:0]     rot_ptr;
    logic [IW-1:0]     pick_ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] wdata;

    // A write already registered this cycle lands in the FIFO at the next
    // edge, so almostfull plus an in-flight write means no room for another.
    assign space_ok = !fifo_full && !(fifo_wr_en && fifo_almostfull);

    // Every write must be acknowledged exactly one cycle after it was issued.
    assign ack_fail = wen_prev_q && !fifo_wr_ack;
    assign err_now  = ack_fail || fifo_overflow;

    // In BURST the picker only matters when ownership is handed over, and
    // then priority starts just after the current owner, which leaves the
    // owner last in line: it wins again only if nobody else is asking.
    assign rot_ptr  = IW'(rr_next(int'(owner), NUM_REQ));
    assign pick_ptr = (state_q == BURST) ? rot_ptr : ptr_q;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner;
        beat_d  = beat_q;
        gnt     = '0;

        case (state_q)
            IDLE: begin
                if (space_ok && pick_any) begin
                    gnt     = pick_gnt;
                    owner_d = pick_idx;
                    beat_d  = BEAT_W'(1);
                    state_d = BURST;
                end
            end

            BURST: begin
                // Without space everything freezes, including the beat count.
                if (space_ok) begin
                    if (req[owner] && (beat_q < BEAT_W'(MAX_BURST))) begin
                        gnt[owner] = 1'b1;
                        beat_d     = beat_q + BEAT_W'(1);
                    end else begin
                        ptr_d = rot_ptr;
                        if (pick_any) begin
                            gnt     = pick_gnt;
                            owner_d = pick_idx;
                            beat_d  = BEAT_W'(1);
                        end else begin
                            beat_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end

            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh error cancels any grant decided above and freezes the
        // arbitration state; it also overrides a simultaneous err_clr.
        if (err_now) begin
            gnt     = '0;
            ptr_d   = ptr_q;
            owner_d = owner;
            beat_d  = beat_q;
            state_d = ERR;
        end

        if (rst) begin
            gnt = '0;
        end
    end

    // Every grant path sets owner_d to the granted index, so it selects
    // the data slice to register.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_d == IW'(i)) begin
                wdata = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q           <= '0;
            owner           <= '0;
            beat_q          <= '0;
            fifo_wr_en      <= 1'b0;
            fifo_data_in    <= '0;
            wen_prev_q      <= 1'b0;
            err_ack_missing <= 1'b0;
            err_overflow    <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            owner      <= owner_d;
            beat_q     <= beat_d;
            fifo_wr_en <= |gnt;
            if (|gnt) begin
                fifo_data_in <= wdata;
            end
            wen_prev_q <= fifo_wr_en;

            if (err_now) begin
                if (ack_fail) begin
                    err_ack_missing <= 1'b1;
                end
                if (fifo_overflow) begin
                    err_overflow <= 1'b1;
                end
            end else if ((state_q == ERR) && err_clr) begin
                err_ack_missing <= 1'b0;
                err_overflow    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a depth-8 FIFO model.
// Reference model tracks ownership/burst rules with plain integers.
// Table vectors, directed corner sequences, then randomized traffic.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int MB    = 4;
    localparam int IW    = 2;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic            fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
    logic            err_clr;
    logic [IW-1:0]   owner;
    logic            err_ack_missing, err_overflow;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .err_clr         (err_clr),
        .owner           (owner),
        .err_ack_missing (err_ack_missing),
        .err_overflow    (err_overflow)
    );

    // ---------------- FIFO model (stimulus side) ----------------
    int   cnt;
    logic ack_r, ovf_r;
    logic drain, kill_ack, inj_ovf;
    logic man, man_full, man_af, man_ack, man_ovf;
    logic fw, fr;

    assign fw = fifo_wr_en && (cnt < DEPTH);
    assign fr = drain && (cnt > 0);

    always @(posedge clk) begin
        if (rst) begin
            cnt   <= 0;
            ack_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            cnt   <= cnt + (fw ? 1 : 0) - (fr ? 1 : 0);
            ack_r <= fw;
            ovf_r <= fifo_wr_en && (cnt == DEPTH);
        end
    end

    assign fifo_full       = man ? man_full : (cnt == DEPTH);
    assign fifo_almostfull = man ? man_af   : (cnt == DEPTH - 1);
    assign fifo_wr_ack     = man ? man_ack  : (ack_r && !kill_ack);
    assign fifo_overflow   = man ? man_ovf  : (ovf_r || inj_ovf);

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = idle, 1 = burst, 2 = error halt
    int            m_mode = 0, m_ptr = 0, m_owner = 0, m_beats = 0;
    bit            m_wen = 0, m_wen_prev = 0, m_eam = 0, m_eo = 0;
    logic [DW-1:0] m_data = '0;

    logic [N-1:0]  g_seen, e_seen;
    logic          s_full, s_af, s_wen;

    function automatic bit bit_of(input logic [N-1:0] r, input int i);
        logic [IW-1:0] k;
        k = IW'(i);
        return r[k];
    endfunction

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (bit_of(r, (start + k) % N)) return (start + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: inputs are already set (at the falling edge). Predict
    // the grant, compare, advance the model, then compare registered outputs.
    task automatic cycle();
        bit space, ack_fail, err_now, cont, rot;
        int w;
        #1;
        s_full   = fifo_full;
        s_af     = fifo_almostfull;
        s_wen    = fifo_wr_en;
        space    = !fifo_full && !(m_wen && fifo_almostfull);
        ack_fail = m_wen_prev && !fifo_wr_ack;
        err_now  = ack_fail || fifo_overflow;
        w = -1; cont = 0; rot = 0;
        if (!rst && m_mode != 2 && !err_now && space) begin
            if (m_mode == 0) begin
                w = first_from(req, m_ptr);
            end else if (bit_of(req, m_owner) && m_beats < MB) begin
                w = m_owner; cont = 1;
            end else begin
                rot = 1;
                w = first_from(req, (m_owner + 1) % N);
            end
        end
        e_seen = (w >= 0) ? (N'(1) << w) : '0;
        g_seen = gnt;
        chk("gnt", 64'(gnt), 64'(e_seen));

        if (rst) begin
            m_mode = 0; m_ptr = 0; m_owner = 0; m_beats = 0;
            m_wen = 0; m_wen_prev = 0; m_eam = 0; m_eo = 0; m_data = '0;
        end else begin
            m_wen_prev = m_wen;
            m_wen      = (w >= 0);
            if (w >= 0) m_data = DW'(req_data >> (w * DW));
            if (err_now) begin
                if (ack_fail) m_eam = 1;
                if (fifo_overflow) m_eo = 1;
                m_mode = 2;
            end else if (m_mode == 2) begin
                if (err_clr) begin
                    m_eam = 0; m_eo = 0; m_mode = 0;
                end
            end else begin
                if (rot) m_ptr = (m_owner + 1) % N;
                if (cont) begin
                    m_beats++;
                end else if (w >= 0) begin
                    m_owner = w; m_beats = 1; m_mode = 1;
                end else if (rot) begin
                    m_mode = 0; m_beats = 0;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("wr_en", 64'(fifo_wr_en), 64'(m_wen));
        chk("data_in", 64'(fifo_data_in), 64'(m_data));
        chk("owner", 64'(owner), 64'(m_owner));
        chk("err_ack_missing", 64'(err_ack_missing), 64'(m_eam));
        chk("err_overflow", 64'(err_overflow), 64'(m_eo));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic         af;
        logic [N-1:0] gnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int grants, viol_full, viol_af;
        bit prev_wen;

        rst = 1'b1; req = '0; req_data = '0; err_clr = 1'b0;
        drain = 1'b0; kill_ack = 1'b0; inj_ovf = 1'b0;
        man = 1'b0; man_full = 1'b0; man_af = 1'b0; man_ack = 1'b0; man_ovf = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_gnt", 64'(g_seen), 64'(0));
        chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("rst_data", 64'(fifo_data_in), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_errs", 64'({err_ack_missing, err_overflow}), 64'(0));

        // ---- table: first grant from reset state under forced FIFO flags ----
        vecs[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{4'b0001, 1'b0, 1'b0, 4'b0001};
        vecs[2] = '{4'b1010, 1'b0, 1'b0, 4'b0010};
        vecs[3] = '{4'b1000, 1'b0, 1'b0, 4'b1000};
        vecs[4] = '{4'b1111, 1'b1, 1'b0, 4'b0000};
        vecs[5] = '{4'b0110, 1'b0, 1'b1, 4'b0010};
        vecs[6] = '{4'b1100, 1'b0, 1'b0, 4'b0100};
        vecs[7] = '{4'b0101, 1'b1, 1'b1, 4'b0000};
        man = 1'b1;
        for (int v = 0; v < 8; v++) begin
            do_reset();
            req_data = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
            req = vecs[v].req; man_full = vecs[v].full; man_af = vecs[v].af;
            cycle();
            chk("table_gnt", 64'(g_seen), 64'(vecs[v].gnt));
        end
        man = 1'b0; man_full = 1'b0; man_af = 1'b0;

        // ---- single producer, empty FIFO: 4 beats then same-cycle re-grant ----
        do_reset();
        req = 4'b0001; drain = 1'b0; prev_wen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_data[DW-1:0] = DW'(16'h1000 + k);
            cycle();
            if (k < 5) chk("seq1_gnt", 64'(g_seen), 64'(4'b0001));
            chk("seq1_wen_follows", 64'(fifo_wr_en), 64'(g_seen != 0));
            chk("seq1_ack_follows", 64'(fifo_wr_ack), 64'(prev_wen));
            prev_wen = fifo_wr_en;
        end
        chk("seq1_no_err", 64'({err_ack_missing, err_overflow}), 64'(0));

        // ---- all request, drained FIFO: ownership 0,1,2,3,0 x4 beats ----
        do_reset();
        req = 4'b1111; drain = 1'b1;
        for (int k = 0; k < 20; k++) begin
            req_data = {$urandom, $urandom};
            cycle();
            chk("seq2_gnt", 64'(g_seen), 64'(4'b0001 << ((k / 4) % 4)));
            chk("seq2_owner", 64'(owner), 64'((k / 4) % 4));
        end

        // ---- fill an 8-deep FIFO without reads ----
        do_reset();
        req = 4'b0010; drain = 1'b0; grants = 0; viol_full = 0; viol_af = 0;
        for (int k = 0; k < 20; k++) begin
            req_data[2*DW-1:DW] = DW'($urandom);
            cycle();
            if (g_seen[1]) grants++;
            if (s_wen && s_full) viol_full++;
            if (s_af && s_wen && g_seen != 0) viol_af++;
        end
        chk("seq3_grants", 64'(grants), 64'(8));
        chk("seq3_wen_when_full", 64'(viol_full), 64'(0));
        chk("seq3_gnt_at_af", 64'(viol_af), 64'(0));
        chk("seq3_full", 64'(fifo_full), 64'(1));
        chk("seq3_no_ovf", 64'(err_overflow), 64'(0));

        // ---- missing ack -> ERR, clear resumes from rr pointer ----
        do_reset();
        req = 4'b0100; drain = 1'b1;
        for (int k = 0; k < 6; k++) cycle();     // rotation at beat 4 moves ptr to 3
        kill_ack = 1'b1;
        cycle();
        kill_ack = 1'b0;
        chk("ack_err_set", 64'(err_ack_missing), 64'(1));
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("err_gnt_zero", 64'(g_seen), 64'(0));
        end
        chk("ack_err_sticky", 64'(err_ack_missing), 64'(1));
        req = 4'b1001; err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("ack_err_cleared", 64'(err_ack_missing), 64'(0));
        cycle();
        chk("resume_from_ptr", 64'(g_seen), 64'(4'b1000));

        // ---- overflow and err_clr together: error wins ----
        inj_ovf = 1'b1; err_clr = 1'b1;
        cycle();
        inj_ovf = 1'b0; err_clr = 1'b0;
        chk("ovf_wins_clr", 64'(err_overflow), 64'(1));
        cycle();
        chk("ovf_stays_err", 64'(g_seen), 64'(0));
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("ovf_cleared", 64'({err_ack_missing, err_overflow}), 64'(0));

        // ---- reset mid-burst at beat 2 ----
        do_reset();
        req = 4'b1111; drain = 1'b1;
        cycle(); cycle();
        rst = 1'b1; req = '0;
        cycle();
        rst = 1'b0;
        chk("midrst_wen", 64'(fifo_wr_en), 64'(0));
        chk("midrst_owner", 64'(owner), 64'(0));
        chk("midrst_errs", 64'({err_ack_missing, err_overflow}), 64'(0));
        cycle();
        chk("midrst_gnt", 64'(g_seen), 64'(0));
        req = 4'b1100;
        cycle();
        chk("midrst_first", 64'(g_seen), 64'(4'b0100));

        // ---- randomized traffic against the model ----
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drain    = ($urandom_range(0, 99) < 70);
            kill_ack = ($urandom_range(0, 63) == 0);
            inj_ovf  = ($urandom_range(0, 127) == 0);
            err_clr  = (m_mode == 2) && ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            if (rst) req = '0;
            cycle();
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req[i] || e_seen[i]) begin
                    req[i] = ($urandom_range(0, 99) < 60);
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
